apb_regfile_responder: RTL and testbench
========================================

Name: apb_regfile_responder

Overview:
- APB completer (responder) for the 4-bit address / 8-bit data APB bus driven by the team's APB initiator.
- Contains a small register file: a read-only ID register, a control register that sets the number of wait states, and general read/write registers.
- Inserts a programmable number of wait states and flags illegal accesses with pslverr.
- Sits on the shared pclk bus as the target for initiator write and read tasks.

Parameters:
- ADDR_W, 4, paddr width.
- DATA_W, 8, pwdata/prdata width.
- NUM_REGS, 16, number of implemented addresses (0..NUM_REGS-1); range 3..2**ADDR_W.
- ID_VALUE, 8'hA5, constant returned at address 0.
- WAIT_RESET, 0, reset value of CTRL[2:0], the wait-state count (0..7).

Ports:
- pclk  input  1  bus clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- paddr  input  ADDR_W  transfer address.
- pwrite  input  1  1 = write, 0 = read.
- psel  input  1  responder select.
- penable  input  1  access phase indicator.
- pwdata  input  DATA_W  write data.
- prdata  output  DATA_W  read data, registered.
- pready  output  1  transfer-complete, registered.
- pslverr  output  1  error response, valid while pready=1.

Behaviour:
- Clock and reset: one clock, pclk; reset rst is synchronous and active-high.
- On reset:
  - prdata=0, pready=0, pslverr=0, state=IDLE.
  - CTRL = {zeros, WAIT_RESET[2:0]}.
  - Registers 2..NUM_REGS-1 = 0.
- Register map:
  - 0 = ID. Read-only, returns ID_VALUE.
  - 1 = CTRL. Full DATA_W read/write; bits[2:0] = wait count W.
  - 2..NUM_REGS-1 = general read/write.
  - Any address >= NUM_REGS is illegal.
- State machine (states IDLE, ACCESS):
  - IDLE: at a rising edge with psel=1 and penable=0 (setup), latch paddr, pwrite, pwdata.
    - Load cnt=CTRL[2:0]; this W applies to the whole transfer even if CTRL changes later.
    - Set pready <= (W==0), go to ACCESS.
  - ACCESS, psel=1, penable=1, pready=1 (completion edge):
    - If legal write, commit pwdata to the register.
    - pready <= 0, pslverr <= 0, go to IDLE.
    - If psel=1 and penable=0 at this same edge (back-to-back setup), it is handled as the IDLE setup case in the same cycle.
  - ACCESS, psel=1, penable=1, pready=0: cnt <= cnt-1; pready <= (cnt==1).
    - pready therefore rises after exactly W access cycles; total transfer = 2+W cycles.
  - ACCESS, psel=0 (abort): return to IDLE, no write, pready=0.
- Read data:
  - prdata is loaded at the setup edge from the addressed register: ID_VALUE for address 0, 0 for illegal addresses.
  - prdata then holds that value until the next setup edge.
- Error response:
  - pslverr is set at the setup edge (alongside pready timing) for:
    - an address >= NUM_REGS, read or write;
    - a write to address 0.
  - pslverr is driven only while pready=1 and is 0 otherwise.
  - An erroring write modifies nothing.
- Protocol violations:
  - penable=1 while in IDLE (no prior setup) is ignored; pready stays 0.
  - Changes to paddr, pwrite or pwdata during ACCESS are ignored, because values are latched at setup.
- Reset mid-transfer: rst overrides everything. The pending write is dropped, all outputs and registers return to their reset values, and the next transfer needs a fresh setup.
- Write to CTRL: takes effect from the next setup edge.

Test Plan:
- Default wait states (W=0):
  - Reset, then read addr 0 -> prdata=8'hA5, pready high in the first access cycle, pslverr=0, transfer = 2 cycles.
  - Write addr 2 = 5 and addr 5 = 10, then read both back -> 5 and 10.
  - Read addr 3 -> 0.
- Programmable wait states: write CTRL = 3, then write addr 4 = 7.
  - The write to CTRL itself completes with 0 waits.
  - The next transfer sees pready=0 for 3 access cycles, then high on the 4th (5 cycles total).
  - Read addr 4 -> 7, also with 3 waits.
- Illegal accesses:
  - Write addr 0 = 8'h00 -> pslverr=1 with pready; read addr 0 afterwards -> still 8'hA5.
  - With NUM_REGS=8, read addr 9 -> pslverr=1, prdata=0.
  - With NUM_REGS=8, write addr 12 -> pslverr=1, no register changes.
- Abort: W=2, start a write to addr 6 = 8'h33, drop psel after 1 access cycle -> pready never asserts; read addr 6 -> 0.
- Reset mid-transfer: W=4, start a write to addr 7, assert rst for 1 cycle mid-wait.
  - Expect pready=0 and pslverr=0.
  - Read CTRL -> WAIT_RESET.
  - Read addr 7 -> 0.
- Back-to-back and protocol violation:
  - Back-to-back writes with no idle gap (setup directly after the completion edge) -> both commit.
  - penable=1 without a setup cycle -> no response.

Source files
------------

// File: rtl/apb_regfile_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : apb_regfile_responder
//  Description : APB completer with a small register file.
//                addr 0          : read-only ID register (ID_VALUE)
//                addr 1          : CTRL, bits[2:0] = wait states per transfer
//                addr 2..N-1     : general read/write registers
//                addr >= N       : illegal, answered with pslverr
//  Ports       : pclk, rst            - clock, synchronous active-high reset
//                paddr, pwrite, psel,
//                penable, pwdata      - APB request from the initiator
//                prdata, pready,
//                pslverr              - registered APB response
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_regfile_responder #(
   parameter int                 ADDR_W     = 4,
   parameter int                 DATA_W     = 8,
   parameter int                 NUM_REGS   = 16,
   parameter logic [DATA_W-1:0]  ID_VALUE   = 8'hA5,
   parameter int                 WAIT_RESET = 0
) (
   input  logic              pclk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] paddr,
   input  logic              pwrite,
   input  logic              psel,
   input  logic              penable,
   input  logic [DATA_W-1:0] pwdata,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              pslverr
);

   localparam logic [0:0]        S_IDLE     = 1'b0;
   localparam logic [0:0]        S_ACCESS   = 1'b1;
   localparam logic [ADDR_W:0]   c_NUM_REGS = (ADDR_W+1)'(NUM_REGS);
   localparam logic [DATA_W-1:0] c_CTRL_RST = DATA_W'(WAIT_RESET & 7);

   logic [0:0]        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic              r_write;
   logic [DATA_W-1:0] r_wdata;
   logic [2:0]        r_cnt;
   logic              r_err;
   logic              r_pready;
   logic              r_pslverr;
   logic [DATA_W-1:0] r_prdata;
   // Index 0 is the constant ID, so storage starts at 1 (CTRL).
   logic [DATA_W-1:0] r_regs [1:NUM_REGS-1];

   logic              w_setup;
   logic              w_legal;
   logic              w_err;
   logic [2:0]        w_wait;
   logic [DATA_W-1:0] w_rdata;
   logic              w_commit;

   // A setup phase is recognised in either state so that a new transfer
   // can start on the edge right after a completion.
   assign w_setup  = psel & ~penable;
   assign w_legal  = ({1'b0, paddr} < c_NUM_REGS);
   assign w_err    = ~w_legal | (pwrite & (paddr == '0));
   assign w_wait   = r_regs[1][2:0];
   assign w_commit = (r_state == S_ACCESS) & psel & penable & r_pready
                   & r_write & ~r_err;

   // Read mux; illegal addresses fall through to zero.
   always_comb begin
      w_rdata = '0;
      if (paddr == '0) begin
         w_rdata = ID_VALUE;
      end
      for (int i = 1; i < NUM_REGS; i++) begin
         if (paddr == ADDR_W'(i)) begin
            w_rdata = r_regs[i];
         end
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            r_regs[i] <= (i == 1) ? c_CTRL_RST : '0;
         end
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (w_commit && (r_addr == ADDR_W'(i))) begin
               r_regs[i] <= r_wdata;
            end
         end
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_addr    <= '0;
         r_write   <= 1'b0;
         r_wdata   <= '0;
         r_cnt     <= 3'd0;
         r_err     <= 1'b0;
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
         r_prdata  <= '0;
      end else if (w_setup) begin
         // Latch the whole request; the wait count is frozen here so a
         // later CTRL write cannot stretch or shorten this transfer.
         r_state   <= S_ACCESS;
         r_addr    <= paddr;
         r_write   <= pwrite;
         r_wdata   <= pwdata;
         r_cnt     <= w_wait;
         r_err     <= w_err;
         r_pready  <= (w_wait == 3'd0);
         r_pslverr <= w_err & (w_wait == 3'd0);
         r_prdata  <= w_rdata;
      end else if (r_state == S_ACCESS) begin
         if (!psel) begin
            // Abort: drop the transfer without writing.
            r_state   <= S_IDLE;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
         end else if (penable) begin
            if (r_pready) begin
               r_state   <= S_IDLE;
               r_pready  <= 1'b0;
               r_pslverr <= 1'b0;
            end else begin
               r_cnt     <= r_cnt - 3'd1;
               r_pready  <= (r_cnt == 3'd1);
               r_pslverr <= r_err & (r_cnt == 3'd1);
            end
         end
      end
   end

   assign prdata  = r_prdata;
   assign pready  = r_pready;
   assign pslverr = r_pslverr;

endmodule
`default_nettype wire

// File: tb/tb_apb_regfile_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_apb_regfile_responder
//  Description : Self-checking bench for apb_regfile_responder (NUM_REGS=8).
//                A transaction-level register model predicts pready,
//                pslverr and prdata for every cycle; directed scenarios
//                are followed by randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_regfile_responder;

   localparam int          AW = 4;
   localparam int          DW = 8;
   localparam int          NR = 8;
   localparam int          WR = 0;
   localparam logic [7:0]  ID = 8'hA5;

   logic          pclk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] paddr = '0;
   logic          pwrite = 1'b0;
   logic          psel = 1'b0;
   logic          penable = 1'b0;
   logic [DW-1:0] pwdata = '0;
   logic [DW-1:0] prdata;
   logic          pready;
   logic          pslverr;

   apb_regfile_responder #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .NUM_REGS  (NR),
      .ID_VALUE  (ID),
      .WAIT_RESET(WR)
   ) u_dut (
      .pclk    (pclk),
      .rst     (rst),
      .paddr   (paddr),
      .pwrite  (pwrite),
      .psel    (psel),
      .penable (penable),
      .pwdata  (pwdata),
      .prdata  (prdata),
      .pready  (pready),
      .pslverr (pslverr)
   );

   always #5 pclk = ~pclk;

   int         n_checks = 0;
   int         n_fail   = 0;
   bit         chk_en   = 1'b0;
   logic       exp_pready  = 1'b0;
   logic       exp_pslverr = 1'b0;
   logic [7:0] exp_prdata  = 8'h00;

   // Register model
   logic [7:0] m_ctrl;
   logic [7:0] m_regs [0:15];

   // Cycle-by-cycle compare against the model's expectation.
   always @(negedge pclk) begin
      if (chk_en) begin
         n_checks++;
         if (pready !== exp_pready) begin
            n_fail++;
            $display("FAIL cyc_pready t=%0t got %b want %b", $time, pready, exp_pready);
         end
         n_checks++;
         if (pslverr !== exp_pslverr) begin
            n_fail++;
            $display("FAIL cyc_pslverr t=%0t got %b want %b", $time, pslverr, exp_pslverr);
         end
         n_checks++;
         if (prdata !== exp_prdata) begin
            n_fail++;
            $display("FAIL cyc_prdata t=%0t got %h want %h", $time, prdata, exp_prdata);
         end
      end
   end

   task automatic check(input string name, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   function automatic logic [7:0] model_read(input logic [3:0] a);
      if (a == 4'd0)       return ID;
      if (int'(a) >= NR)   return 8'h00;
      if (a == 4'd1)       return m_ctrl;
      return m_regs[a];
   endfunction

   function automatic bit model_err(input logic [3:0] a, input bit wr);
      return (int'(a) >= NR) || (wr && (a == 4'd0));
   endfunction

   task automatic model_reset();
      m_ctrl = 8'(WR & 7);
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
      exp_prdata  = 8'h00;
      exp_pready  = 1'b0;
      exp_pslverr = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         exp_pready  = 1'b0;
         exp_pslverr = 1'b0;
         psel    = 1'b0;
         penable = 1'b0;
         paddr   = 4'($urandom);
         pwdata  = 8'($urandom);
         step();
      end
   endtask

   // One APB transfer. abort_after >= 0 drops psel on that access cycle.
   // rd/er/waits are DUT observations for literal checks.
   task automatic xfer(input logic [3:0] a, input bit wr, input logic [7:0] d,
                       input int abort_after,
                       output logic [7:0] rd, output bit er, output int waits);
      int w;
      bit e;
      rd = 8'h00; er = 1'b0; waits = 0;
      exp_pready  = 1'b0;
      exp_pslverr = 1'b0;
      psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = d;
      step();
      w = int'(m_ctrl[2:0]);
      e = model_err(a, wr);
      exp_prdata = model_read(a);
      for (int k = 0; k <= w; k++) begin
         exp_pready  = (k == w);
         exp_pslverr = (k == w) && e;
         penable = 1'b1;
         // Request lines wander during access; the DUT must ignore them.
         paddr  = 4'($urandom);
         pwrite = 1'($urandom);
         pwdata = 8'($urandom);
         if (k == abort_after) begin
            psel = 1'b0; penable = 1'b0;
            step();
            exp_pready = 1'b0; exp_pslverr = 1'b0;
            return;
         end
         if (pready === 1'b1) begin
            rd = prdata; er = pslverr;
         end else begin
            waits++;
         end
         step();
      end
      if (wr && !e) begin
         if (a == 4'd1) m_ctrl = d;
         else           m_regs[a] = d;
      end
      psel = 1'b0; penable = 1'b0;
      exp_pready = 1'b0; exp_pslverr = 1'b0;
   endtask

   initial begin
      logic [7:0] rd;
      bit         er;
      int         wt;
      int         w;
      int         ab;
      logic [3:0] a;
      bit         wr;
      logic [7:0] d;

      model_reset();
      rst = 1'b1;
      step();
      step();
      chk_en = 1'b1;
      check("reset_prdata", int'(prdata), 0);
      check("reset_pready", int'(pready), 0);
      check("reset_pslverr", int'(pslverr), 0);
      rst = 1'b0;
      idle(2);

      // Default zero wait states
      xfer(4'd0, 1'b0, 8'h00, -1, rd, er, wt);
      check("id_read", int'(rd), 'hA5);
      check("id_err", int'(er), 0);
      check("id_waits", wt, 0);
      xfer(4'd2, 1'b1, 8'd5, -1, rd, er, wt);
      xfer(4'd5, 1'b1, 8'd10, -1, rd, er, wt);
      xfer(4'd2, 1'b0, 8'h00, -1, rd, er, wt);
      check("rd_addr2", int'(rd), 5);
      xfer(4'd5, 1'b0, 8'h00, -1, rd, er, wt);
      check("rd_addr5", int'(rd), 10);
      xfer(4'd3, 1'b0, 8'h00, -1, rd, er, wt);
      check("rd_addr3", int'(rd), 0);

      // Programmable wait states
      xfer(4'd1, 1'b1, 8'd3, -1, rd, er, wt);
      check("ctrl_wr_waits", wt, 0);
      xfer(4'd4, 1'b1, 8'd7, -1, rd, er, wt);
      check("w3_wr_waits", wt, 3);
      xfer(4'd4, 1'b0, 8'h00, -1, rd, er, wt);
      check("w3_rd_data", int'(rd), 7);
      check("w3_rd_waits", wt, 3);
      xfer(4'd1, 1'b1, 8'd0, -1, rd, er, wt);
      idle(1);

      // Illegal accesses
      xfer(4'd0, 1'b1, 8'h00, -1, rd, er, wt);
      check("wr_id_err", int'(er), 1);
      xfer(4'd0, 1'b0, 8'h00, -1, rd, er, wt);
      check("id_after_wr", int'(rd), 'hA5);
      xfer(4'd9, 1'b0, 8'h00, -1, rd, er, wt);
      check("rd9_err", int'(er), 1);
      check("rd9_data", int'(rd), 0);
      xfer(4'd12, 1'b1, 8'h99, -1, rd, er, wt);
      check("wr12_err", int'(er), 1);
      xfer(4'd4, 1'b0, 8'h00, -1, rd, er, wt);
      check("wr12_no_alias", int'(rd), 7);

      // Abort
      xfer(4'd1, 1'b1, 8'd2, -1, rd, er, wt);
      xfer(4'd6, 1'b1, 8'h33, 1, rd, er, wt);
      idle(1);
      xfer(4'd6, 1'b0, 8'h00, -1, rd, er, wt);
      check("abort_rd6", int'(rd), 0);

      // Reset in the middle of a waited write
      xfer(4'd1, 1'b1, 8'd4, -1, rd, er, wt);
      exp_pready = 1'b0; exp_pslverr = 1'b0;
      psel = 1'b1; penable = 1'b0; paddr = 4'd7; pwrite = 1'b1; pwdata = 8'h5C;
      step();
      exp_prdata = model_read(4'd7);
      penable = 1'b1;
      step();
      step();
      rst = 1'b1;
      step();
      model_reset();
      rst = 1'b0; psel = 1'b0; penable = 1'b0;
      check("rstmid_pready", int'(pready), 0);
      check("rstmid_pslverr", int'(pslverr), 0);
      idle(1);
      xfer(4'd1, 1'b0, 8'h00, -1, rd, er, wt);
      check("rstmid_ctrl", int'(rd), WR);
      xfer(4'd7, 1'b0, 8'h00, -1, rd, er, wt);
      check("rstmid_rd7", int'(rd), 0);

      // Back-to-back writes, no idle gap
      xfer(4'd2, 1'b1, 8'h11, -1, rd, er, wt);
      xfer(4'd3, 1'b1, 8'h22, -1, rd, er, wt);
      idle(1);
      xfer(4'd2, 1'b0, 8'h00, -1, rd, er, wt);
      check("b2b_rd2", int'(rd), 'h11);
      xfer(4'd3, 1'b0, 8'h00, -1, rd, er, wt);
      check("b2b_rd3", int'(rd), 'h22);

      // penable without setup
      for (int i = 0; i < 3; i++) begin
         exp_pready = 1'b0; exp_pslverr = 1'b0;
         psel = 1'b1; penable = 1'b1; paddr = 4'd2; pwrite = 1'b1; pwdata = 8'hEE;
         step();
      end
      check("noset_pready", int'(pready), 0);
      idle(1);
      xfer(4'd2, 1'b0, 8'h00, -1, rd, er, wt);
      check("noset_rd2", int'(rd), 'h11);

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         idle(int'($urandom_range(0, 2)));
         a  = 4'($urandom_range(0, 15));
         wr = 1'($urandom);
         d  = 8'($urandom);
         if (a == 4'd1) d[2:0] = 3'($urandom_range(0, 3));
         w  = int'(m_ctrl[2:0]);
         ab = -1;
         if (w > 0 && $urandom_range(0, 7) == 0) ab = int'($urandom_range(0, w - 1));
         xfer(a, wr, d, ab, rd, er, wt);
      end
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
